serial_sub_ctrl: RTL and testbench
==================================

SERIAL_SUB_CTRL -- requirements
Module: serial_sub_ctrl

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8, giving the operand width in bits (legal range 2..32).
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The module SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 The module SHALL have port start, input, 1 bit: request to begin a subtraction.
REQ-005 The module SHALL have port a, input, WIDTH bits: minuend, sampled when start is accepted.
REQ-006 The module SHALL have port b, input, WIDTH bits: subtrahend, sampled when start is accepted.
REQ-007 The module SHALL have port bin, input, 1 bit: borrow-in, sampled when start is accepted.
REQ-008 The module SHALL have port busy, output, 1 bit: high while an operation is in progress.
REQ-009 The module SHALL have port done, output, 1 bit: one-cycle pulse marking the result as valid.
REQ-010 The module SHALL have port diff, output, WIDTH bits: result a - b - bin, modulo 2^WIDTH.
REQ-011 The module SHALL have port bout, output, 1 bit: final borrow-out.

Function
REQ-012 The module SHALL compute the result bit-serially, LSB first, through one internal 1-bit full-subtractor cell reused every cycle.
- d = x ^ y ^ c
- borrow = (~x & y) | (~(x ^ y) & c)
REQ-013 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-014 In IDLE, start=1 SHALL be accepted at that edge.
- a, b and bin latch into shift/borrow registers.
- Bit counter clears to 0.
- State goes to RUN.
REQ-015 In RUN, each edge SHALL process one bit.
- Cell inputs: current LSBs of the a/b shift registers and the borrow register.
- Cell d shifts into the MSB of the result register.
- The a/b registers shift right.
- The borrow register updates.
- The counter increments.
REQ-016 When the counter reaches WIDTH-1, that edge SHALL process the final bit and move the state to DONE.
REQ-017 DONE SHALL last exactly one cycle, then return to IDLE unconditionally.
REQ-018 Timing from the accepting edge E SHALL be as follows.
- busy=1 from after E through the last RUN cycle, i.e. WIDTH cycles.
- done=1 for exactly the one cycle after edge E+WIDTH.
- Total latency: WIDTH+1 cycles.
REQ-019 During DONE and afterwards, diff and bout SHALL hold the final result.
- They stay stable until the next accepted start.
REQ-020 During RUN, diff SHALL show the partially shifted result and bout the running borrow.
- Consumers use them only when done=1 or in IDLE after done.
REQ-021 start in RUN or DONE SHALL be ignored: no restart, no change to the latched operands, no error indication.
REQ-022 Changes on a, b or bin after acceptance SHALL NOT affect the operation in progress.
REQ-023 busy and done SHALL never be high in the same cycle.
REQ-024 The counter SHALL be ceil(log2(WIDTH)) bits wide and SHALL NOT wrap inside an operation.
REQ-025 start held high continuously SHALL start a new operation at the first IDLE cycle after DONE, giving one idle cycle between operations.

Reset
REQ-026 rst=1 at an edge SHALL have the following effect.
- State goes to IDLE.
- busy=0, done=0, diff=0, bout=0.
- Counter, shift registers and borrow register clear.
REQ-027 rst SHALL take priority over start and over any in-flight RUN/DONE activity.
- A reset mid-operation aborts it with no done pulse.
REQ-028 start asserted in the same cycle as rst SHALL be ignored.

Verification (WIDTH=8)
REQ-029 The bench SHALL apply a=0x5A, b=0x3C, bin=0 with a start pulse.
- busy high for 8 cycles.
- done pulses once, 9 cycles after the accepting edge.
- diff=0x1E, bout=0.
REQ-030 The bench SHALL apply a=0x00, b=0x01, bin=0.
- diff=0xFF, bout=1 (wrap-around).
REQ-031 The bench SHALL cover bin propagation.
- a=0x10, b=0x0F, bin=1: diff=0x00, bout=0.
- a=0xFF, b=0xFF, bin=1: diff=0xFF, bout=1.
REQ-032 The bench SHALL start a=0x80, b=0x01, bin=0, then pulse start with a=0x00, b=0x00 mid-RUN.
- The second start is ignored.
- The result is diff=0x7F, bout=0.
- Exactly one done pulse occurs.
REQ-033 The bench SHALL assert rst in the 4th RUN cycle.
- Next cycle: busy=0, diff=0, bout=0, and no done pulse.
- A following start with a=0x03, b=0x01 gives diff=0x02.
REQ-034 The bench SHALL hold start high continuously for 30 cycles.
- Back-to-back operations repeat every 10 cycles (8 RUN + 1 DONE + 1 IDLE).
- Each produces exactly one done pulse.
- busy and done are never high together.

Source files
------------

// File: rtl/serial_sub_ctrl.sv
// serial_sub_ctrl: bit-serial subtractor computing diff = a - b - bin (mod 2^WIDTH).
// One 1-bit full-subtractor cell is reused every cycle, LSB first.
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   start, a, b, bin  - request and operands (sampled when start is accepted in IDLE)
//   busy              - high during the WIDTH RUN cycles
//   done              - one-cycle pulse when diff/bout hold the final result
//   diff, bout        - result and borrow-out (partial/running while busy)
module serial_sub_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [CW-1:0]    cnt;

  // Full-subtractor cell; bout doubles as the running borrow register.
  logic x_c;
  logic y_c;
  logic d_c;
  logic bw_c;

  assign x_c  = sa[0];
  assign y_c  = sb[0];
  assign d_c  = x_c ^ y_c ^ bout;
  assign bw_c = (~x_c & y_c) | (~(x_c ^ y_c) & bout);

  // Control FSM and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      sa    <= '0;
      sb    <= '0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      diff  <= '0;
      bout  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            sa    <= a;
            sb    <= b;
            bout  <= bin;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          diff <= {d_c, diff[WIDTH-1:1]};
          sa   <= sa >> 1;
          sb   <= sb >> 1;
          bout <= bw_c;
          if (cnt == CW'(WIDTH - 1)) begin
            // Last bit: leave the counter parked so it never wraps mid-operation.
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Scoreboard bench for serial_sub_ctrl (WIDTH=8): stimulus pushes expected results,
// a negedge monitor pops and compares on every done pulse.
module tb_serial_sub_ctrl;

  localparam int unsigned W = 8;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         bout;

  serial_sub_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout)
  );

  typedef struct {
    int diff;
    int bout;
    int cyc;
  } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: plain integer arithmetic on the operands.
  task automatic push_exp(input int av, input int bv, input int cv, input int done_cyc);
    exp_t e;
    int   r;
    r      = av - bv - cv;
    e.diff = r & ((1 << W) - 1);
    e.bout = (r < 0) ? 1 : 0;
    e.cyc  = done_cyc;
    sbq.push_back(e);
  endtask

  // Monitor: mutual exclusion of busy/done, and result/latency on each done.
  always @(negedge clk) begin
    exp_t e;
    if (busy && done) check("busy_done_overlap", 1, 0);
    if (done) begin
      if (sbq.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        e = sbq.pop_front();
        check("diff", int'(diff), e.diff);
        check("bout", int'(bout), e.bout);
        check("done_cycle", cyc, e.cyc);
      end
    end
  end

  // One operation; optionally a spurious start (operands 0/0) in RUN cycle ign.
  task automatic do_op(input int av, input int bv, input int cv, input int ign);
    a     = W'(av);
    b     = W'(bv);
    bin   = 1'(cv);
    start = 1'b1;
    push_exp(av, bv, cv, cyc + int'(W) + 1);
    @(negedge clk);
    for (int k = 1; k <= int'(W); k++) begin
      check("busy_run", int'(busy), 1);
      start = (k == ign);
      if (k == ign) begin
        a = '0;
        b = '0;
      end else begin
        a = W'($urandom);
        b = W'($urandom);
      end
      bin = 1'($urandom);
      @(negedge clk);
    end
    start = 1'b0;
    check("busy_done_cycle", int'(busy), 0);
    @(negedge clk);
  endtask

  initial begin
    int n;
    rst   = 1'b1;
    start = 1'b1;
    a     = 8'h12;
    b     = 8'h34;
    bin   = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_diff", int'(diff), 0);
    check("rst_bout", int'(bout), 0);
    rst   = 1'b0;
    start = 1'b0;
    @(negedge clk);
    check("idle_busy", int'(busy), 0);

    // Directed vectors.
    do_op(8'h5A, 8'h3C, 0, -1);
    check("hold_diff", int'(diff), 8'h1E);
    do_op(8'h00, 8'h01, 0, -1);
    check("hold_bout", int'(bout), 1);
    do_op(8'h10, 8'h0F, 1, -1);
    do_op(8'hFF, 8'hFF, 1, -1);
    do_op(8'h80, 8'h01, 0, 3);
    repeat (3) @(negedge clk);
    check("ignored_start_no_op", int'(busy), 0);

    // Reset in the 4th RUN cycle aborts without a done pulse.
    a     = 8'h55;
    b     = 8'h11;
    bin   = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    check("abort_diff", int'(diff), 0);
    check("abort_bout", int'(bout), 0);
    repeat (12) @(negedge clk);
    do_op(8'h03, 8'h01, 0, -1);

    // Random operations with random idle gaps.
    for (int i = 0; i < 20; i++) begin
      do_op(int'($urandom_range(255)), int'($urandom_range(255)), int'($urandom_range(1)), -1);
      repeat ($urandom_range(3)) @(negedge clk);
    end

    // start held high for 30 cycles: accepts every 10 cycles, operands change each cycle.
    n     = cyc;
    start = 1'b1;
    for (int i = 0; i < 30; i++) begin
      a   = W'($urandom);
      b   = W'($urandom);
      bin = 1'($urandom);
      if (i % (int'(W) + 2) == 0) push_exp(int'(a), int'(b), int'(bin), n + i + int'(W) + 1);
      @(negedge clk);
    end
    start = 1'b0;
    repeat (12) @(negedge clk);

    check("scoreboard_empty", sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
